// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: region decode, register offsets, STATUS bit layout.
package mmio_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_TXDATA,
    RGN_STATUS,
    RGN_CYCLES,
    RGN_NONE
  } region_e;

  localparam logic [31:0] OFS_TXDATA = 32'd0;
  localparam logic [31:0] OFS_STATUS = 32'd1;
  localparam logic [31:0] OFS_CYCLES = 32'd2;

  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;

  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] io_base);
    region_e rgn;
    rgn = RGN_NONE;
    if (addr[31:12] == 20'd0)               rgn = RGN_RAM;
    else if (addr == io_base + OFS_TXDATA)  rgn = RGN_TXDATA;
    else if (addr == io_base + OFS_STATUS)  rgn = RGN_STATUS;
    else if (addr == io_base + OFS_CYCLES)  rgn = RGN_CYCLES;
    return rgn;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Byte-wide transmit FIFO with wrap-bit pointers; a pop frees room for a same-cycle push.
module mmio_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_bridge.sv
// Processor data-port bridge: RAM passthrough plus TXDATA/STATUS/CYCLES I/O registers.
// Define MMIO_CYCLE_COUNTER_EN to build the free-running CYCLES counter.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [31:0] IO_BASE = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_wren,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  output logic [31:0] cpu_q,
  output logic        ram_wren,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_data,
  input  logic [31:0] ram_q,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  region_e       region;
  logic          push;
  logic          pop_fire;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   cnt32;
  logic [31:0]   status;
  logic [31:0]   cycles_val;
  logic [31:0]   io_rdata;
  logic          ovf_set;
  logic          ovf_clr;
  region_e       region_p0;
  logic [31:0]   rdata_p0;

  assign region   = decode_region(cpu_addr, IO_BASE);
  assign ram_addr = cpu_addr[11:0];
  assign ram_data = cpu_data;
  assign ram_wren = cpu_wren && (region == RGN_RAM);

  assign push     = cpu_wren && (region == RGN_TXDATA);
  assign tx_valid = ~empty;
  assign pop_fire = tx_valid & tx_ready;

  mmio_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (cpu_data[7:0]),
    .pop       (pop_fire),
    .head      (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // A push into a full FIFO is only lost when no pop frees a slot that cycle.
  assign ovf_set = push && full && !pop_fire;
  assign ovf_clr = cpu_wren && (region == RGN_STATUS) && cpu_data[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycles <= '0;
    else        cycles <= cycles + 32'd1;
  end

  assign cycles_val = cycles;
`else
  assign cycles_val = '0;
`endif

  assign cnt32 = 32'(count);

  always_comb begin
    status             = '0;
    status[7:0]        = cnt32[7:0];
    status[STAT_EMPTY] = empty;
    status[STAT_FULL]  = full;
    status[STAT_OVF]   = overflow;
  end

  always_comb begin
    io_rdata = '0;
    case (region)
      RGN_STATUS: io_rdata = status;
      RGN_CYCLES: io_rdata = cycles_val;
      default:    io_rdata = '0;
    endcase
  end

  // Stage p0: capture region and I/O read value alongside the synchronous RAM read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      region_p0 <= RGN_NONE;
      rdata_p0  <= '0;
    end else begin
      region_p0 <= region;
      rdata_p0  <= io_rdata;
    end
  end

  assign cpu_q = (region_p0 == RGN_RAM) ? ram_q : rdata_p0;

endmodule
